// File: rtl/useq_ctrl_if.sv
// Microsequencer control bundle: instruction fields and flags in, upcreg controls and status out.
interface useq_ctrl_if #(
    parameter int AW = 5,
    parameter int CW = 8
);
    logic          start;
    logic [AW-1:0] upc;
    logic [2:0]    br_op;
    logic [AW-1:0] br_addr;
    logic [1:0]    br_sel;
    logic [3:0]    flags;
    logic          loop_ld;
    logic [CW-1:0] loop_val;
    logic          load_incr;
    logic [AW-1:0] upc_next;
    logic          busy;
    logic          done;
    logic          stack_err;

    modport master (
        output start, upc, br_op, br_addr, br_sel, flags, loop_ld, loop_val,
        input  load_incr, upc_next, busy, done, stack_err
    );

    modport slave (
        input  start, upc, br_op, br_addr, br_sel, flags, loop_ld, loop_val,
        output load_incr, upc_next, busy, done, stack_err
    );
endinterface

// File: rtl/useq_ctrl.sv
// Microsequencer controller: decodes the branch field each cycle and steers upcreg
// (load vs. increment), with a return stack, loop counter and start/done handshake.
//
// state | meaning
// IDLE  | after reset, waiting for start; upc held
// RUN   | executing microcode, branch field decoded every cycle
// DONE  | halted (HALT or RET on empty stack); upc held, start relaunches
module useq_ctrl #(
    parameter int            AW         = 5,
    parameter int            DEPTH      = 4,
    parameter int            CW         = 8,
    parameter logic [AW-1:0] START_ADDR = '0
) (
    input logic      clk,
    input logic      reset,
    useq_ctrl_if.slave bus
);

    localparam int IW  = $clog2(DEPTH);
    localparam int SPW = IW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_NEXT  = 3'd0,
        OP_JMP   = 3'd1,
        OP_JCOND = 3'd2,
        OP_CALL  = 3'd3,
        OP_RET   = 3'd4,
        OP_LOOP  = 3'd5,
        OP_WAITC = 3'd6,
        OP_HALT  = 3'd7
    } br_op_t;

    state_t          state_q, state_d;
    logic [SPW-1:0]  sp_q, sp_d;
    logic [CW-1:0]   loop_cnt_q, loop_cnt_d;
    logic            stack_err_q, stack_err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [AW-1:0]   stack_q [DEPTH];

    logic            load_incr;
    logic [AW-1:0]   upc_next;
    logic            push_en;
    logic [AW-1:0]   push_data;
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   rd_idx;
    logic            flag_sel;
    logic            stack_full;
    logic            stack_empty;

    // Stack pointer decode: sp counts entries, so the top lives at sp-1 and the
    // low bits of sp-1 wrap correctly even when sp == DEPTH.
    always_comb begin
        wr_idx      = sp_q[IW-1:0];
        rd_idx      = sp_q[IW-1:0] - IW'(1);
        stack_full  = (sp_q == SPW'(DEPTH));
        stack_empty = (sp_q == '0);
        flag_sel    = bus.flags[bus.br_sel];
    end

    // Next-state and upcreg steering; default is hold (load current upc).
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        loop_cnt_d  = loop_cnt_q;
        stack_err_d = stack_err_q;
        load_incr   = 1'b1;
        upc_next    = bus.upc;
        push_en     = 1'b0;
        push_data   = bus.upc + AW'(1);

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    upc_next    = START_ADDR;
                    state_d     = S_RUN;
                    sp_d        = '0;
                    stack_err_d = 1'b0;
                end
            end
            S_RUN: begin
                unique case (bus.br_op)
                    OP_NEXT:  load_incr = 1'b0;
                    OP_JMP:   upc_next = bus.br_addr;
                    OP_JCOND: begin
                        if (flag_sel) upc_next  = bus.br_addr;
                        else          load_incr = 1'b0;
                    end
                    OP_CALL: begin
                        // Overflow drops the push but the jump still happens.
                        if (stack_full) begin
                            stack_err_d = 1'b1;
                        end else begin
                            push_en = 1'b1;
                            sp_d    = sp_q + SPW'(1);
                        end
                        upc_next = bus.br_addr;
                    end
                    OP_RET: begin
                        if (stack_empty) begin
                            stack_err_d = 1'b1;
                            state_d     = S_DONE;
                        end else begin
                            upc_next = stack_q[rd_idx];
                            sp_d     = sp_q - SPW'(1);
                        end
                    end
                    OP_LOOP: begin
                        if (loop_cnt_q != '0) begin
                            loop_cnt_d = loop_cnt_q - CW'(1);
                            upc_next   = bus.br_addr;
                        end else begin
                            load_incr = 1'b0;
                        end
                    end
                    OP_WAITC: begin
                        if (flag_sel) load_incr = 1'b0;
                    end
                    OP_HALT:  state_d = S_DONE;
                    default:  load_incr = 1'b1;
                endcase
            end
            default: state_d = S_IDLE;
        endcase

        // An explicit load overrides any same-cycle LOOP decrement.
        if (bus.loop_ld) loop_cnt_d = bus.loop_val;

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // Control state, stack pointer, loop counter and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sp_q        <= '0;
            loop_cnt_q  <= '0;
            stack_err_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            loop_cnt_q  <= loop_cnt_d;
            stack_err_q <= stack_err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Return-stack storage; contents need no reset since sp gates every read.
    always_ff @(posedge clk) begin
        if (push_en) stack_q[wr_idx] <= push_data;
    end

    assign bus.load_incr = load_incr;
    assign bus.upc_next  = upc_next;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.stack_err = stack_err_q;

endmodule

// File: doc/useq_ctrl.md
Name: useq_ctrl

Overview:
Microsequencer controller that drives the micro-program counter register (upcreg). Each cycle it decodes the branch field of the current microinstruction and the condition flags, then produces load_incr and upc_next. It implements jumps, conditional branches, subroutine call/return through an internal return stack, counted loops, wait-on-condition and halt, plus a start/done handshake to the host control.

Parameters:
AW, 5, micro-address width; must match the upc register width.
DEPTH, 4, return-stack entries (power of 2, at least 2).
CW, 8, loop-counter width.
START_ADDR, 0, micro-address loaded on start.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  launch request; sampled in IDLE or DONE
upc  in  AW  current micro-PC from upcreg
br_op  in  3  branch op of current microinstruction: 0 NEXT, 1 JMP, 2 JCOND, 3 CALL, 4 RET, 5 LOOP, 6 WAITC, 7 HALT
br_addr  in  AW  branch target
br_sel  in  2  selects flags[br_sel] for JCOND/WAITC
flags  in  4  datapath condition inputs
loop_ld  in  1  load the loop counter
loop_val  in  CW  loop counter load value
load_incr  out  1  to upcreg: 1 = load upc_next, 0 = increment
upc_next  out  AW  to upcreg load value
busy  out  1  high in RUN
done  out  1  high in DONE
stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- States are IDLE, RUN, DONE. Reset, asynchronous, forces: state=IDLE, sp=0, loop_cnt=0, stack_err=0. Stack contents are don't-care.
- load_incr and upc_next are combinational from state, br_op, flags, upc, stack top and loop_cnt. They have zero latency: upcreg takes effect on the next clk edge.
- Hold: upcreg cannot hold, so hold means load_incr=1 and upc_next=upc.
- IDLE: hold. busy=0, done=0. If start=1, then load_incr=1, upc_next=START_ADDR, and next state is RUN.
- DONE: hold. done=1. If start=1, it behaves like IDLE+start: stack_err is cleared, sp=0, and next state is RUN.
- RUN (busy=1), by br_op:
  - NEXT: load_incr=0.
  - JMP: load br_addr.
  - JCOND: load br_addr if flags[br_sel]=1, else load_incr=0.
  - CALL: push (upc+1) mod 2^AW, then load br_addr.
  - RET: load stack[sp-1] and pop.
  - LOOP: if loop_cnt != 0, then loop_cnt <= loop_cnt-1 and load br_addr; else load_incr=0 and the counter is unchanged.
  - WAITC: hold while flags[br_sel]=0, load_incr=0 once it is 1.
  - HALT: hold, and next state is DONE.
- Stack boundaries:
  - CALL with sp=DEPTH: the push is dropped, stack_err <= 1, and the jump still occurs.
  - RET with sp=0: stack_err <= 1, hold, and next state is DONE.
  - sp saturates at 0 and DEPTH; it never wraps.
- Loop counter: loop_ld=1 writes loop_val in any state. It wins over a same-cycle LOOP decrement. The LOOP branch decision uses the pre-load value.
- Address arithmetic is modulo 2^AW. Increment of upc=2^AW-1 wraps to 0 inside upcreg. A return address from CALL at the top address is 0.
- br_op, br_sel and br_addr are ignored outside RUN. flags are sampled only for JCOND and WAITC.
- Reset asserted mid-RUN aborts immediately. upcreg is reset by the same signal.

Test Plan:
- Reset, then start pulse with START_ADDR=0 and program NEXT,NEXT,HALT. Expected: upc sequence 0,1,2,2,2…; busy=1 for 3 cycles; then done=1, load_incr=1, upc_next=2.
- JCOND at upc=3, br_sel=2, br_addr=10. With flags=4'b0100 next upc=10; with flags=0 next upc=4.
- CALL at upc=5 to 20, RET at 20. Expected: upc 5→20→6; sp goes 0→1→0; stack_err=0. Five nested CALLs with DEPTH=4: stack_err=1 after the fifth, and upc still jumps.
- loop_ld with loop_val=3, then LOOP at upc=8 targeting 6 with NEXT at 6,7. Expected: branch taken 3 times, fall through to 9 on the 4th visit, loop_cnt=0.
- WAITC on flags[0] at upc=12: upc stays 12 for 5 cycles while flags[0]=0, then 13 the cycle after flags[0]=1. Assert reset mid-wait: state returns to IDLE and busy=0 immediately.
- RET with empty stack: stack_err=1, done=1, hold. A following start clears stack_err and upc restarts at START_ADDR.
